// File: rtl/sap1_pkg.sv
// SAP-1 controller shared definitions: opcodes, T-state encoding, control word.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Encoding order is visible on the tstate debug port.
  typedef enum logic [2:0] {
    T1     = 3'd0,
    T2     = 3'd1,
    T3     = 3'd2,
    WAIT   = 3'd3,
    T4     = 3'd4,
    T5     = 3'd5,
    T6     = 3'd6,
    HALTED = 3'd7
  } tstate_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_en_n;
    logic mar_load_n;
    logic ram_en_n;
    logic ir_load_n;
    logic ir_en_n;
    logic a_load_n;
    logic a_en_n;
    logic b_load_n;
    logic alu_sub;
    logic alu_en_n;
    logic out_load_n;
    logic halt;
  } ctrl_word_t;

  // Every strobe deasserted: active-low ones high, active-high ones low.
  localparam ctrl_word_t CTRL_IDLE = '{
    pc_inc:     1'b0,
    pc_en_n:    1'b1,
    mar_load_n: 1'b1,
    ram_en_n:   1'b1,
    ir_load_n:  1'b1,
    ir_en_n:    1'b1,
    a_load_n:   1'b1,
    a_en_n:     1'b1,
    b_load_n:   1'b1,
    alu_sub:    1'b0,
    alu_en_n:   1'b1,
    out_load_n: 1'b1,
    halt:       1'b0
  };

endpackage

// File: rtl/sap1_ring_counter.sv
// T-state sequencer: owns the state register and the IR-settle wait counter.
module sap1_ring_counter
  import sap1_pkg::*;
#(
  parameter int IR_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_hlt,
  output logic [2:0] tstate
);

  // Reload value so that WAIT lasts exactly IR_LAT cycles.
  localparam logic [1:0] LAT_M1 = (IR_LAT > 0) ? 2'(IR_LAT - 1) : 2'd0;

  tstate_t    state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  // State and wait-counter registers; reset returns to the start of fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T1;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: fetch, optional settle wait, execute, or park in HALTED.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      T1: state_nxt = T2;
      T2: state_nxt = T3;
      T3: begin
        if (IR_LAT > 0) begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_M1;
        end else begin
          state_nxt = T4;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) state_nxt = T4;
        else             cnt_nxt   = cnt - 2'd1;
      end
      T4:      state_nxt = is_hlt ? HALTED : T5;
      T5:      state_nxt = T6;
      T6:      state_nxt = T1;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = T1;
    endcase
  end

  assign tstate = state;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: Moore decode of the T-state plus live opcode
// into the active-low datapath strobes.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int IR_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  output logic            pc_inc,
  output logic            pc_en_n,
  output logic            mar_load_n,
  output logic            ram_en_n,
  output logic            ir_load_n,
  output logic            ir_en_n,
  output logic            a_load_n,
  output logic            a_en_n,
  output logic            b_load_n,
  output logic            alu_sub,
  output logic            alu_en_n,
  output logic            out_load_n,
  output logic            halt,
  output logic [2:0]      tstate
);

  localparam logic [OP_W-1:0] C_LDA = OP_W'(OP_LDA);
  localparam logic [OP_W-1:0] C_ADD = OP_W'(OP_ADD);
  localparam logic [OP_W-1:0] C_SUB = OP_W'(OP_SUB);
  localparam logic [OP_W-1:0] C_OUT = OP_W'(OP_OUT);
  localparam logic [OP_W-1:0] C_HLT = OP_W'(OP_HLT);

  tstate_t    st;
  ctrl_word_t cw;
  logic       is_hlt;

  assign is_hlt = (opcode == C_HLT);

  sap1_ring_counter #(.IR_LAT(IR_LAT)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .is_hlt (is_hlt),
    .tstate (tstate)
  );

  assign st = tstate_t'(tstate);

  // Control-word decode; opcode only matters in T4-T6, and reset masks everything.
  always_comb begin
    cw = CTRL_IDLE;
    case (st)
      T1: begin
        cw.pc_en_n    = 1'b0;
        cw.mar_load_n = 1'b0;
      end
      T2: cw.pc_inc = 1'b1;
      T3: begin
        cw.ram_en_n  = 1'b0;
        cw.ir_load_n = 1'b0;
      end
      T4: begin
        if (opcode == C_LDA || opcode == C_ADD || opcode == C_SUB) begin
          cw.ir_en_n    = 1'b0;
          cw.mar_load_n = 1'b0;
        end else if (opcode == C_OUT) begin
          cw.a_en_n     = 1'b0;
          cw.out_load_n = 1'b0;
        end else if (opcode == C_HLT) begin
          cw.halt = 1'b1;
        end
      end
      T5: begin
        if (opcode == C_LDA) begin
          cw.ram_en_n = 1'b0;
          cw.a_load_n = 1'b0;
        end else if (opcode == C_ADD || opcode == C_SUB) begin
          cw.ram_en_n = 1'b0;
          cw.b_load_n = 1'b0;
        end
      end
      T6: begin
        if (opcode == C_ADD || opcode == C_SUB) begin
          cw.alu_en_n = 1'b0;
          cw.a_load_n = 1'b0;
          cw.alu_sub  = (opcode == C_SUB);
        end
      end
      HALTED:  cw.halt = 1'b1;
      default: cw = CTRL_IDLE;
    endcase
    if (rst) cw = CTRL_IDLE;
  end

  assign pc_inc     = cw.pc_inc;
  assign pc_en_n    = cw.pc_en_n;
  assign mar_load_n = cw.mar_load_n;
  assign ram_en_n   = cw.ram_en_n;
  assign ir_load_n  = cw.ir_load_n;
  assign ir_en_n    = cw.ir_en_n;
  assign a_load_n   = cw.a_load_n;
  assign a_en_n     = cw.a_en_n;
  assign b_load_n   = cw.b_load_n;
  assign alu_sub    = cw.alu_sub;
  assign alu_en_n   = cw.alu_en_n;
  assign out_load_n = cw.out_load_n;
  assign halt       = cw.halt;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller: one IR_LAT=1 instance, one IR_LAT=0 instance.
module tb_sap1_controller;

  // Output word layout: {pc_inc, pc_en_n, mar_load_n, ram_en_n, ir_load_n,
  // ir_en_n, a_load_n, a_en_n, b_load_n, alu_sub, alu_en_n, out_load_n, halt}
  localparam logic [12:0] IDLE     = 13'b0111111110110;
  localparam logic [12:0] M_PC_INC = 13'h1 << 12;
  localparam logic [12:0] M_PC_EN  = 13'h1 << 11;
  localparam logic [12:0] M_MAR    = 13'h1 << 10;
  localparam logic [12:0] M_RAM    = 13'h1 << 9;
  localparam logic [12:0] M_IRL    = 13'h1 << 8;
  localparam logic [12:0] M_IREN   = 13'h1 << 7;
  localparam logic [12:0] M_AL     = 13'h1 << 6;
  localparam logic [12:0] M_AEN    = 13'h1 << 5;
  localparam logic [12:0] M_BL     = 13'h1 << 4;
  localparam logic [12:0] M_SUB    = 13'h1 << 3;
  localparam logic [12:0] M_ALUEN  = 13'h1 << 2;
  localparam logic [12:0] M_OUTL   = 13'h1 << 1;
  localparam logic [12:0] M_HALT   = 13'h1;

  // Toggling a bit away from idle makes that strobe active.
  localparam logic [12:0] W_T1   = IDLE ^ (M_PC_EN | M_MAR);
  localparam logic [12:0] W_T2   = IDLE ^ M_PC_INC;
  localparam logic [12:0] W_T3   = IDLE ^ (M_RAM | M_IRL);
  localparam logic [12:0] W_ADR  = IDLE ^ (M_IREN | M_MAR);
  localparam logic [12:0] W_LDA5 = IDLE ^ (M_RAM | M_AL);
  localparam logic [12:0] W_B5   = IDLE ^ (M_RAM | M_BL);
  localparam logic [12:0] W_ADD6 = IDLE ^ (M_ALUEN | M_AL);
  localparam logic [12:0] W_SUB6 = IDLE ^ (M_ALUEN | M_AL | M_SUB);
  localparam logic [12:0] W_OUT4 = IDLE ^ (M_AEN | M_OUTL);
  localparam logic [12:0] W_HALT = IDLE ^ M_HALT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic       rst_a, rst_b;
  logic [3:0] op_a, op_b;

  logic pc_inc_a, pc_en_n_a, mar_load_n_a, ram_en_n_a, ir_load_n_a, ir_en_n_a;
  logic a_load_n_a, a_en_n_a, b_load_n_a, alu_sub_a, alu_en_n_a, out_load_n_a, halt_a;
  logic [2:0] ts_a;
  logic pc_inc_b, pc_en_n_b, mar_load_n_b, ram_en_n_b, ir_load_n_b, ir_en_n_b;
  logic a_load_n_b, a_en_n_b, b_load_n_b, alu_sub_b, alu_en_n_b, out_load_n_b, halt_b;
  logic [2:0] ts_b;
  logic [12:0] cw_a, cw_b;

  assign cw_a = {pc_inc_a, pc_en_n_a, mar_load_n_a, ram_en_n_a, ir_load_n_a, ir_en_n_a,
                 a_load_n_a, a_en_n_a, b_load_n_a, alu_sub_a, alu_en_n_a, out_load_n_a, halt_a};
  assign cw_b = {pc_inc_b, pc_en_n_b, mar_load_n_b, ram_en_n_b, ir_load_n_b, ir_en_n_b,
                 a_load_n_b, a_en_n_b, b_load_n_b, alu_sub_b, alu_en_n_b, out_load_n_b, halt_b};

  sap1_controller #(.OP_W(4), .IR_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(op_a),
    .pc_inc(pc_inc_a), .pc_en_n(pc_en_n_a), .mar_load_n(mar_load_n_a),
    .ram_en_n(ram_en_n_a), .ir_load_n(ir_load_n_a), .ir_en_n(ir_en_n_a),
    .a_load_n(a_load_n_a), .a_en_n(a_en_n_a), .b_load_n(b_load_n_a),
    .alu_sub(alu_sub_a), .alu_en_n(alu_en_n_a), .out_load_n(out_load_n_a),
    .halt(halt_a), .tstate(ts_a)
  );

  sap1_controller #(.OP_W(4), .IR_LAT(0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(op_b),
    .pc_inc(pc_inc_b), .pc_en_n(pc_en_n_b), .mar_load_n(mar_load_n_b),
    .ram_en_n(ram_en_n_b), .ir_load_n(ir_load_n_b), .ir_en_n(ir_en_n_b),
    .a_load_n(a_load_n_b), .a_en_n(a_en_n_b), .b_load_n(b_load_n_b),
    .alu_sub(alu_sub_b), .alu_en_n(alu_en_n_b), .out_load_n(out_load_n_b),
    .halt(halt_b), .tstate(ts_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of instance A: check now (inputs already driven), then advance.
  task automatic cyc_a(input string tag, input logic [2:0] ts, input logic [12:0] w,
                       input bit chk_ts = 1'b1);
    #1;
    if (chk_ts) check({tag, "_ts"}, {13'b0, ts_a}, {13'b0, ts});
    check({tag, "_cw"}, {3'b0, cw_a}, {3'b0, w});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input string tag, input logic [2:0] ts, input logic [12:0] w);
    #1;
    check({tag, "_ts"}, {13'b0, ts_b}, {13'b0, ts});
    check({tag, "_cw"}, {3'b0, cw_b}, {3'b0, w});
    @(posedge clk);
    #1;
  endtask

  // Full instruction on instance A; opcode is junk (HLT) until T4 to show it is ignored.
  task automatic instr_a(input string tag, input logic [3:0] op,
                         input logic [12:0] w4, input logic [12:0] w5, input logic [12:0] w6);
    op_a = 4'b1111;
    cyc_a({tag, "_t1"}, 3'd0, W_T1);
    cyc_a({tag, "_t2"}, 3'd1, W_T2);
    cyc_a({tag, "_t3"}, 3'd2, W_T3);
    cyc_a({tag, "_wait"}, 3'd3, IDLE);
    op_a = op;
    cyc_a({tag, "_t4"}, 3'd4, w4);
    cyc_a({tag, "_t5"}, 3'd5, w5);
    cyc_a({tag, "_t6"}, 3'd6, w6);
  endtask

  // Bus-contention invariant on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    check("bus_a", {15'b0, $countones(~{pc_en_n_a, ram_en_n_a, ir_en_n_a, a_en_n_a, alu_en_n_a}) <= 1}, 16'd1);
    check("bus_b", {15'b0, $countones(~{pc_en_n_b, ram_en_n_b, ir_en_n_b, a_en_n_b, alu_en_n_b}) <= 1}, 16'd1);
  end

  initial begin
    rst_a = 1'b1; op_a = 4'b0000;
    rst_b = 1'b1; op_b = 4'b0101;
    #1;
    cyc_a("rst0", 3'd0, IDLE, 1'b0);
    cyc_a("rst1", 3'd0, IDLE, 1'b0);
    cyc_a("rst2", 3'd0, IDLE);
    rst_a = 1'b0;

    instr_a("lda", 4'b0000, W_ADR, W_LDA5, IDLE);
    instr_a("sub", 4'b0010, W_ADR, W_B5, W_SUB6);
    instr_a("add", 4'b0001, W_ADR, W_B5, W_ADD6);
    instr_a("out", 4'b1110, W_OUT4, IDLE, IDLE);
    instr_a("unk", 4'b0101, IDLE, IDLE, IDLE);

    // Reset during LDA T5: the a_load_n pulse must not appear.
    op_a = 4'b0000;
    cyc_a("ldr_t1", 3'd0, W_T1);
    cyc_a("ldr_t2", 3'd1, W_T2);
    cyc_a("ldr_t3", 3'd2, W_T3);
    cyc_a("ldr_wait", 3'd3, IDLE);
    cyc_a("ldr_t4", 3'd4, W_ADR);
    rst_a = 1'b1;
    cyc_a("ldr_t5rst", 3'd5, IDLE);
    rst_a = 1'b0;
    instr_a("post_rst", 4'b0001, W_ADR, W_B5, W_ADD6);

    // HLT: park in HALTED regardless of later opcode changes.
    op_a = 4'b1111;
    cyc_a("hlt_t1", 3'd0, W_T1);
    cyc_a("hlt_t2", 3'd1, W_T2);
    cyc_a("hlt_t3", 3'd2, W_T3);
    cyc_a("hlt_wait", 3'd3, IDLE);
    cyc_a("hlt_t4", 3'd4, W_HALT);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) op_a = 4'b0000;
      cyc_a($sformatf("halted%0d", i), 3'd7, W_HALT);
    end
    rst_a = 1'b1;
    cyc_a("hlt_rst", 3'd7, IDLE);
    rst_a = 1'b0;
    instr_a("post_hlt", 4'b0000, W_ADR, W_LDA5, IDLE);
    cyc_a("post_hlt_next", 3'd0, W_T1);

    // IR_LAT=0 build: T3 goes straight to T4; unknown opcode runs as NOP.
    rst_b = 1'b0;
    cyc_b("b_t1", 3'd0, W_T1);
    cyc_b("b_t2", 3'd1, W_T2);
    cyc_b("b_t3", 3'd2, W_T3);
    cyc_b("b_t4", 3'd4, IDLE);
    cyc_b("b_t5", 3'd5, IDLE);
    cyc_b("b_t6", 3'd6, IDLE);
    op_b = 4'b0010;
    cyc_b("b2_t1", 3'd0, W_T1);
    cyc_b("b2_t2", 3'd1, W_T2);
    cyc_b("b2_t3", 3'd2, W_T3);
    cyc_b("b2_t4", 3'd4, W_ADR);
    cyc_b("b2_t5", 3'd5, W_B5);
    cyc_b("b2_t6", 3'd6, W_SUB6);
    cyc_b("b2_next", 3'd0, W_T1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
